// File: rtl/display_scheduler_if.sv
// Display scheduler signal bundle: base-page inputs, message handshake and the eight display digits.
interface display_scheduler_if;
    logic [15:0] time_bcd;
    logic [15:0] score_bcd;
    logic        blink_en;
    logic        msg_req;
    logic [31:0] msg_data;
    logic        msg_cancel;
    logic        msg_ack;
    logic        msg_busy;
    logic [3:0]  display7;
    logic [3:0]  display6;
    logic [3:0]  display5;
    logic [3:0]  display4;
    logic [3:0]  display3;
    logic [3:0]  display2;
    logic [3:0]  display1;
    logic [3:0]  display0;

    modport master (
        output time_bcd, score_bcd, blink_en, msg_req, msg_data, msg_cancel,
        input  msg_ack, msg_busy,
        input  display7, display6, display5, display4,
        input  display3, display2, display1, display0
    );

    modport slave (
        input  time_bcd, score_bcd, blink_en, msg_req, msg_data, msg_cancel,
        output msg_ack, msg_busy,
        output display7, display6, display5, display4,
        output display3, display2, display1, display0
    );
endinterface

// File: rtl/display_scheduler.sv
// Chooses what the 8-digit display shows: timer/score base page, or a timed message borrowed
// through a req/ack handshake. Also blinks the timer field and blanks leading score zeros.
module display_scheduler #(
    parameter int unsigned HOLD_TICKS  = 100_000_000,
    parameter int unsigned BLINK_TICKS = 25_000_000
) (
    input  logic               clk,
    input  logic               rst,
    display_scheduler_if.slave bus
);

    localparam int unsigned HOLD_W  = (HOLD_TICKS  > 1) ? $clog2(HOLD_TICKS)  : 1;
    localparam int unsigned BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int unsigned DIGITS  = 8;
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);
    localparam logic [3:0]         BLANK      = 4'hF;

    typedef enum logic {
        ST_BASE = 1'b0,
        ST_MSG  = 1'b1
    } state_t;

    state_t               state, state_nxt;
    logic [HOLD_W-1:0]    hold_cnt, hold_cnt_nxt;
    logic [BLINK_W-1:0]   blink_cnt, blink_cnt_nxt;
    logic                 blink_hidden, blink_hidden_nxt;
    logic [31:0]          msg_reg, msg_reg_nxt;
    logic                 ack_nxt;
    logic                 ack_q, busy_q;
    logic [31:0]          disp_nxt, disp_q;
    logic [15:0]          score;
    logic [3:0]           nib;

    // State, counters and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_BASE;
            hold_cnt     <= '0;
            blink_cnt    <= '0;
            blink_hidden <= 1'b0;
            msg_reg      <= '1;
            ack_q        <= 1'b0;
            busy_q       <= 1'b0;
            disp_q       <= '1;
        end else begin
            state        <= state_nxt;
            hold_cnt     <= hold_cnt_nxt;
            blink_cnt    <= blink_cnt_nxt;
            blink_hidden <= blink_hidden_nxt;
            msg_reg      <= msg_reg_nxt;
            ack_q        <= ack_nxt;
            busy_q       <= (state_nxt == ST_MSG);
            disp_q       <= disp_nxt;
        end
    end

    // Next-state, blink phase and display selection
    always_comb begin
        state_nxt        = state;
        hold_cnt_nxt     = hold_cnt;
        msg_reg_nxt      = msg_reg;
        ack_nxt          = 1'b0;
        blink_cnt_nxt    = '0;
        blink_hidden_nxt = 1'b0;
        disp_nxt         = '1;
        score            = bus.score_bcd;
        nib              = 4'h0;

        if (state == ST_BASE) begin
            if (bus.msg_req && !bus.msg_cancel) begin
                state_nxt    = ST_MSG;
                msg_reg_nxt  = bus.msg_data;
                hold_cnt_nxt = HOLD_LAST;
                ack_nxt      = 1'b1;
            end
        end else begin
            if ((hold_cnt == '0) || bus.msg_cancel) begin
                state_nxt = ST_BASE;
            end else begin
                hold_cnt_nxt = hold_cnt - HOLD_W'(1);
            end
        end

        // Counter stays parked at zero with the phase visible whenever blinking is off
        if (bus.blink_en) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt_nxt    = '0;
                blink_hidden_nxt = ~blink_hidden;
            end else begin
                blink_cnt_nxt    = blink_cnt + BLINK_W'(1);
                blink_hidden_nxt = blink_hidden;
            end
        end

        if (state == ST_MSG) begin
            for (int i = 0; i < DIGITS; i++) begin
                nib = msg_reg[i*4 +: 4];
                disp_nxt[i*4 +: 4] = (nib > 4'd9) ? BLANK : nib;
            end
        end else begin
            disp_nxt[31:16] = blink_hidden ? 16'hFFFF : bus.time_bcd;
            // Leading-zero blanking only looks at zero nibbles; non-BCD values count as nonzero
            disp_nxt[15:12] = (score[15:12] == 4'h0) ? BLANK : score[15:12];
            disp_nxt[11:8]  = (score[15:8]  == 8'h0) ? BLANK : score[11:8];
            disp_nxt[7:4]   = (score[15:4]  == 12'h0) ? BLANK : score[7:4];
            disp_nxt[3:0]   = score[3:0];
        end
    end

    assign bus.msg_ack  = ack_q;
    assign bus.msg_busy = busy_q;
    assign bus.display7 = disp_q[31:28];
    assign bus.display6 = disp_q[27:24];
    assign bus.display5 = disp_q[23:20];
    assign bus.display4 = disp_q[19:16];
    assign bus.display3 = disp_q[15:12];
    assign bus.display2 = disp_q[11:8];
    assign bus.display1 = disp_q[7:4];
    assign bus.display0 = disp_q[3:0];

endmodule

// File: doc/display_scheduler.md
# display_scheduler

Owns the eight BCD digit inputs of the 7-segment display driver and decides what the display shows. The default base page is the game timer on the left four digits and the score on the right four. Other game blocks can borrow the whole display for a timed message through a request/acknowledge handshake. The block also blinks the timer field on request and suppresses leading zeros in the score.

## Interface
- `HOLD_TICKS`, default 100_000_000: clk cycles a message stays in the message state. Must be ≥1.
- `BLINK_TICKS`, default 25_000_000: clk cycles per blink half-period. Must be ≥1.
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `time_bcd` in 16: timer digits t3..t0 (t3 = bits 15:12).
- `score_bcd` in 16: score digits s3..s0 (s3 = bits 15:12).
- `blink_en` in 1: blink the timer field while high.
- `msg_req` in 1: level request to show a message.
- `msg_data` in 32: message nibbles m7..m0 (m7 = bits 31:28). Any nibble >9 renders blank.
- `msg_cancel` in 1: abort the current message, or block acceptance in this cycle.
- `msg_ack` out 1: one-cycle pulse confirming that the request was accepted.
- `msg_busy` out 1: high while in state MSG.
- `display7`…`display0` out 4 each: digits to the display driver, left to right. 4'hF means blank.

## Operation
- Two states: BASE (after reset) and MSG.
- **BASE → MSG:** taken at any edge where the state is BASE, `msg_req`=1 and `msg_cancel`=0.
  - `msg_data` is latched into the message register.
  - `hold_cnt` is loaded with HOLD_TICKS-1.
  - `msg_ack` is registered to 1 for exactly one cycle.
- **In MSG:** `msg_req` is ignored and `msg_data` changes have no effect.
- **MSG → BASE:** taken at an edge with `hold_cnt`==0 or `msg_cancel`=1. Otherwise `hold_cnt` decrements.
  - Expiry and cancel in the same cycle give a single return to BASE.
- **Re-acceptance:** the state is BASE for at least one cycle before a new acceptance. If `msg_req` is still high, the next acceptance happens at the edge after the return.
- **Base page, timer field (`display7..4`):**
  - `display7..4` = t3..t0.
  - When the blink phase is HIDDEN, all four are 4'hF.
- **Base page, score field (`display3..0`):**
  - `display3` = blank if s3==0.
  - `display2` = blank if s3==s2==0.
  - `display1` = blank if s3==s2==s1==0.
  - `display0` = s0, always shown.
  - Non-BCD nibbles pass through unchanged and count as nonzero.
- **Message page:** `display7..0` = m7..m0 as latched.
- **Blink logic:**
  - While `blink_en`=0: `blink_cnt`=0 and the phase is VISIBLE.
  - While `blink_en`=1: `blink_cnt` counts 0..BLINK_TICKS-1. At the wrap edge the phase toggles and the count returns to 0.
  - Blink keeps running during MSG but only affects the base page.
- **Width and overflow:**
  - `hold_cnt` is wide enough for HOLD_TICKS-1; `blink_cnt` is wide enough for BLINK_TICKS-1.
  - Neither counter wraps beyond its terminal value.

## Timing
- **Reset values** (at the edge where `rst`=1):
  - state BASE, `msg_ack`=0, `msg_busy`=0.
  - `display7..0`=4'hF (all blank).
  - `blink_cnt`=0, phase VISIBLE, message register cleared to all 4'hF.
- **Reset mid-message:** immediate return to BASE. No `msg_ack` is produced, and the display is blank for one cycle.
- **Registered outputs:**
  - All outputs are registered.
  - `display*` reflect the state and inputs sampled at the previous edge, i.e. one cycle of latency.
  - A base-page input change at edge N appears after edge N+1.
- **Acceptance at edge E:**
  - `msg_ack`=1 and `msg_busy`=1 during cycle E..E+1.
  - The display shows the message from edge E+1.
- **Message duration with no cancel:**
  - `msg_busy` is high for exactly HOLD_TICKS cycles and falls at edge E+HOLD_TICKS.
  - The base page returns at edge E+HOLD_TICKS+1.
- **Cancel at edge C** (state MSG): `msg_busy` falls at C, and the base page returns at C+1.
- **Blink period:** the phase toggles every BLINK_TICKS cycles. The first HIDDEN phase starts BLINK_TICKS edges after `blink_en` is sampled high.

## Test plan
- **Reset and base page:** assert `rst` for 2 cycles, then `time_bcd`=16'h0059 and `score_bcd`=16'h0007.
  - During reset: all displays read F.
  - One cycle after release: `display7..0` = 0,0,5,9,F,F,F,7.
- **Message:** HOLD_TICKS=4; pulse `msg_req` with `msg_data`=32'h12345678.
  - `msg_ack` is high for exactly one cycle and `msg_busy` is high for 4 cycles.
  - The display shows 1..8 for 4 cycles, then the base page.
  - A `msg_data` change mid-message is ignored.
- **Cancel:** hold `msg_req` high and assert `msg_cancel` in the 2nd MSG cycle.
  - `msg_busy` drops at that edge.
  - The base page shows for one cycle, then re-acceptance with a second `msg_ack`.
- **Cancel blocks acceptance:** in BASE, raise `msg_req`=1 and `msg_cancel`=1 together.
  - No `msg_ack` is produced and the state stays BASE.
- **Blink:** BLINK_TICKS=3; hold `blink_en`=1.
  - `display7..4` alternate between t-digits and F every 3 cycles while the score is unaffected.
  - Dropping `blink_en` gives visible digits one cycle later.
- **Reset mid-message:** assert `rst` during MSG.
  - `msg_busy`=0 and the displays are all F.
  - After release: base page with no stray `msg_ack`.
